// File: rtl/cache_pkg.sv
// Shared FSM state encoding and tag-block field layout for the cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_COMPARE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_ALLOCATE  = 3'd4
    } state_t;

    // Tag block layout is {valid, dirty, tag}. Field positions are counted
    // down from the block MSB so they hold for any tag width.
    localparam int VALID_POS = 0;
    localparam int DIRTY_POS = 1;

    // Absolute bit index of a field inside a tag block of the given width
    function automatic int blk_bit(input int tag_mem_w, input int pos_from_top);
        return tag_mem_w - 1 - pos_from_top;
    endfunction

endpackage

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache FSM driving external tag and data arrays; optional CACHE_STATS_EN adds hit/miss counters.
// Latency: hit completes one cycle after accept; misses add write-back and/or refill memory round trips.
// Backpressure: cpu_req is held until accepted in IDLE; mem_req and its payload are held until mem_ack.
module cache_controller
    import cache_pkg::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int OFFSET_W  = 2,
    parameter  int IDX_W     = 5,
    localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W,
    localparam int TAG_MEM_W = TAG_W + 2
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic [IDX_W-1:0]     idx,
    output logic                 tag_we,
    output logic [TAG_MEM_W-1:0] tag_block_in,
    input  logic [TAG_MEM_W-1:0] tag_block_out,
    input  logic [31:0]          data_out,
    output logic                 data_we,
`ifdef CACHE_STATS_EN
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
`endif
    output logic [31:0]          data_in
);

    localparam int VB = blk_bit(TAG_MEM_W, VALID_POS);
    localparam int DB = blk_bit(TAG_MEM_W, DIRTY_POS);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   init_cnt;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic               req_we;
    logic [31:0]        req_wdata;
    logic               evicted;
    logic               ack_q;

    logic               st_valid;
    logic               st_dirty;
    logic [TAG_W-1:0]   st_tag;
    logic               hit;
    logic               need_wb;
    logic               accept;

    // Byte offset within the word never affects a full-word line
    logic               unused_offset;
    assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

    assign st_valid = tag_block_out[VB];
    assign st_dirty = tag_block_out[DB];
    assign st_tag   = tag_block_out[TAG_W-1:0];
    assign hit      = st_valid && (st_tag == req_tag);
    // Once the victim has been written back, the stale dirty bit is ignored
    assign need_wb  = st_valid && st_dirty && !hit && !evicted;
    assign accept   = (state == ST_IDLE) && cpu_req;

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Init sweep counter, walks every set once after reset
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Request capture on accept; address split into tag and index once
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            req_tag   <= '0;
            req_idx   <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
        end else if (accept) begin
            req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
            req_idx   <= cpu_addr[OFFSET_W +: IDX_W];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
        end
    end

    // Eviction-done flag and post-ack gap tracking for the memory port
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            evicted <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= mem_req && mem_ack;
            if (accept) begin
                evicted <= 1'b0;
            end else if ((state == ST_WRITEBACK) && mem_ack) begin
                evicted <= 1'b1;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        idx          = req_idx;
        tag_we       = 1'b0;
        tag_block_in = '0;
        data_we      = 1'b0;
        data_in      = req_wdata;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            ST_INIT: begin
                idx    = init_cnt;
                tag_we = iRST_N;
                if (init_cnt == {IDX_W{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cpu_req) begin
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (need_wb) begin
                    state_nxt = ST_WRITEBACK;
                end else if (req_we) begin
                    // Full-word line: a store never needs the old contents
                    data_we                  = 1'b1;
                    data_in                  = req_wdata;
                    tag_we                   = 1'b1;
                    tag_block_in[VB]         = 1'b1;
                    tag_block_in[DB]         = 1'b1;
                    tag_block_in[TAG_W-1:0]  = req_tag;
                    cpu_ready                = 1'b1;
                    state_nxt                = ST_IDLE;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_out;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {st_tag, req_idx, {OFFSET_W{1'b0}}};
                mem_wdata = data_out;
                if (mem_ack) begin
                    state_nxt = req_we ? ST_COMPARE : ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                // Drop mem_req for one cycle after a write-back ack
                mem_req  = !ack_q;
                mem_addr = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (!ack_q && mem_ack) begin
                    data_we                  = 1'b1;
                    data_in                  = mem_rdata;
                    tag_we                   = 1'b1;
                    tag_block_in[VB]         = 1'b1;
                    tag_block_in[TAG_W-1:0]  = req_tag;
                    state_nxt                = ST_COMPARE;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic first_lookup;

    // Only the first COMPARE of a request counts; refill re-lookups do not
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            first_lookup <= 1'b0;
        end else if (accept) begin
            first_lookup <= 1'b1;
        end else if (state == ST_COMPARE) begin
            first_lookup <= 1'b0;
        end
    end

    // Saturating hit and miss counters
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == ST_COMPARE) && first_lookup) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: external tag/data arrays, randomly-acking memory, and a line-level cache model.
// Latency: hit accesses are required to complete one cycle after accept.
// Backpressure: memory acks arrive after random delays; the reset case withholds the ack entirely.
module tb_cache_controller;

    localparam int ADDR_W    = 32;
    localparam int OFFSET_W  = 2;
    localparam int IDX_W     = 5;
    localparam int TAG_W     = 25;
    localparam int TAG_MEM_W = 27;
    localparam int NSETS     = 32;

    logic                 iCLK = 1'b0;
    logic                 iRST_N = 1'b0;
    logic                 cpu_req = 1'b0;
    logic                 cpu_we = 1'b0;
    logic [31:0]          cpu_addr = '0;
    logic [31:0]          cpu_wdata = '0;
    logic [31:0]          cpu_rdata;
    logic                 cpu_ready;
    logic                 mem_req;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_ack;
    logic [IDX_W-1:0]     idx;
    logic                 tag_we;
    logic [TAG_MEM_W-1:0] tag_block_in;
    logic [TAG_MEM_W-1:0] tag_block_out;
    logic [31:0]          data_out;
    logic                 data_we;
    logic [31:0]          data_in;
`ifdef CACHE_STATS_EN
    logic [31:0]          hit_cnt;
    logic [31:0]          miss_cnt;
`endif

    always #5 iCLK = ~iCLK;

    cache_controller #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .IDX_W(IDX_W)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .idx(idx), .tag_we(tag_we), .tag_block_in(tag_block_in), .tag_block_out(tag_block_out),
        .data_out(data_out), .data_we(data_we),
`ifdef CACHE_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .data_in(data_in)
    );

    // ---------------- environment: external arrays and backing memory ----------------
    logic [TAG_MEM_W-1:0] tag_arr [NSETS];
    logic [31:0]          data_arr [NSETS];
    assign tag_block_out = tag_arr[idx];
    assign data_out      = data_arr[idx];
    always @(posedge iCLK) begin
        if (tag_we)  tag_arr[idx]  <= tag_block_in;
        if (data_we) data_arr[idx] <= data_in;
    end

    // Initial memory contents for words never written
    function automatic logic [31:0] fill_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] bmem [logic [31:0]];
    logic        resp_en = 1'b1;
    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = resp_rdata;

    initial begin
        forever begin
            @(posedge iCLK);
            #1;
            resp_ack = 1'b0;
            if (resp_en && iRST_N && mem_req && ($urandom_range(0, 2) == 0)) begin
                resp_ack = 1'b1;
                if (mem_we) bmem[mem_addr] = mem_wdata;
                else        resp_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : fill_word(mem_addr);
            end
        end
    end

    // ---------------- reference model: one line per set, architectural memory ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    bit          r_valid [NSETS];
    bit          r_dirty [NSETS];
    logic [31:0] r_tag   [NSETS];
    logic [31:0] r_data  [NSETS];
    logic [31:0] rmem [logic [31:0]];
    mtx_t        exp_mem[$];
    mtx_t        obs_mem[$];
    int          mdl_hits = 0;
    int          mdl_misses = 0;

    function automatic void model_reset();
        for (int i = 0; i < NSETS; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
        end
        mdl_hits = 0;
        mdl_misses = 0;
        exp_mem.delete();
    endfunction

    function automatic void model_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                         output bit hit, output logic [31:0] rd);
        int          s;
        logic [31:0] t;
        logic [31:0] line;
        logic [31:0] victim;
        s    = int'((a / 4) % NSETS);
        t    = a / (4 * NSETS);
        line = a - (a % 4);
        hit  = r_valid[s] && (r_tag[s] == t);
        if (hit) mdl_hits++;
        else     mdl_misses++;
        if (!hit && r_valid[s] && r_dirty[s]) begin
            victim = r_tag[s] * (4 * NSETS) + s * 4;
            exp_mem.push_back('{1'b1, victim, r_data[s]});
            rmem[victim] = r_data[s];
        end
        if (!hit && !we) begin
            exp_mem.push_back('{1'b0, line, 32'h0});
            r_data[s]  = rmem.exists(line) ? rmem[line] : fill_word(line);
            r_dirty[s] = 1'b0;
        end
        if (we) begin
            r_data[s]  = wd;
            r_dirty[s] = 1'b1;
        end
        r_valid[s] = 1'b1;
        r_tag[s]   = t;
        rd = r_data[s];
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    bit          cur_active = 1'b0;
    bit          cur_we = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] seen_rdata = '0;
    int          ready_cnt = 0;

    // Per-cycle compare of CPU completions and memory transactions against the model
    initial begin
        bit   mem_pend;
        mtx_t held;
        mtx_t e;
        mem_pend = 1'b0;
        held = '0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                mem_pend = 1'b0;
            end else begin
                if (cpu_ready && cur_active) begin
                    ready_cnt++;
                    seen_rdata = cpu_rdata;
                    if (!cur_we) check("cpu_rdata", cpu_rdata, exp_rdata);
                end
                if (cpu_ready && !cur_active) check("stray_cpu_ready", cpu_ready, 0);
                if (mem_req) begin
                    check("mem_addr_align", mem_addr[1:0], 0);
                    if (!mem_pend) begin
                        if (exp_mem.size() == 0) begin
                            check("unexpected_mem_req", mem_req, 0);
                        end else begin
                            e = exp_mem.pop_front();
                            check("mem_we", mem_we, e.we);
                            check("mem_addr", mem_addr, e.addr);
                            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                        end
                        held = '{mem_we, mem_addr, mem_wdata};
                        obs_mem.push_back(held);
                        mem_pend = 1'b1;
                    end else begin
                        check("mem_hold", {mem_we, mem_addr, mem_wdata}, held);
                    end
                    if (mem_ack) mem_pend = 1'b0;
                end
            end
        end
    end

    // Drive one CPU access and wait for its completion
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, output int lat);
        bit          hit;
        logic [31:0] rd;
        int          s;
        model_access(we, a, wd, hit, rd);
        s = int'((a / 4) % NSETS);
        cur_we = we;
        exp_rdata = rd;
        ready_cnt = 0;
        obs_mem.delete();
        cur_active = 1'b1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        @(negedge iCLK);
        cpu_req = 1'b0;
        lat = 1;
        while (!cpu_ready && lat < 400) begin
            @(negedge iCLK);
            lat++;
        end
        if (!cpu_ready) check("cpu_ready_timeout", cpu_ready, 1);
        if (hit) check("hit_latency", lat, 1);
        @(negedge iCLK);
        @(negedge iCLK);
        check("ready_pulses", ready_cnt, 1);
        check("mem_txns_outstanding", exp_mem.size(), 0);
        if (we) begin
            check("wr_tag_block", tag_arr[s], {2'b11, r_tag[s][TAG_W-1:0]});
            check("wr_data_word", data_arr[s], wd);
        end
        cur_active = 1'b0;
    endtask

    // After reset release: one set cleared per cycle, then IDLE
    task automatic init_check();
        for (int i = 0; i < NSETS; i++) begin
            #1;
            check("init_tag_we", tag_we, 1);
            check("init_idx", idx, i);
            check("init_tag_block", tag_block_in, 0);
            check("init_cpu_ready", cpu_ready, 0);
            check("init_mem_req", mem_req, 0);
            @(negedge iCLK);
            force_ack = 1'b0;
        end
        #1;
        check("idle_tag_we", tag_we, 0);
        check("idle_cpu_ready", cpu_ready, 0);
    endtask

    // Reset asserted while a refill is outstanding; a stale ack then lands in INIT
    task automatic reset_abort();
        int n;
        resp_en = 1'b0;
        @(negedge iCLK);
        exp_mem.push_back('{1'b0, 32'h0000_3014, 32'h0});
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h0000_3014;
        @(negedge iCLK);
        cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge iCLK);
            n++;
        end
        check("abort_refill_req", mem_req, 1);
        check("abort_refill_addr", mem_addr, 32'h0000_3014);
        repeat (2) @(negedge iCLK);
        check("abort_req_held", mem_req, 1);
        check("abort_refill_consumed", exp_mem.size(), 0);
        iRST_N = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_tag_we", tag_we, 0);
        check("rst_data_we", data_we, 0);
        check("rst_cpu_ready", cpu_ready, 0);
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        model_reset();
        @(negedge iCLK);
        iRST_N = 1'b1;
        resp_rdata = 32'hBAD0_BAD0;
        force_ack = 1'b1;
        init_check();
        resp_en = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] a;
        bit          we;
        model_reset();
        repeat (3) @(negedge iCLK);
        #1;
        check("rst_cpu_ready_por", cpu_ready, 0);
        check("rst_mem_req_por", mem_req, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        init_check();

        // Cold read, then warm read of the same word
        bmem[32'h40] = 32'hDEAD_BEEF;
        rmem[32'h40] = 32'hDEAD_BEEF;
        access(1'b0, 32'h40, 32'h0, lat);
        check("cold_rdata_lit", seen_rdata, 32'hDEAD_BEEF);
        check("cold_mem_count", obs_mem.size(), 1);
        if (obs_mem.size() > 0) check("cold_mem_addr_lit", obs_mem[0].addr, 32'h40);
        access(1'b0, 32'h40, 32'h0, lat);
        check("warm_latency_lit", lat, 1);
        check("warm_no_mem", obs_mem.size(), 0);
        check("warm_rdata_lit", seen_rdata, 32'hDEAD_BEEF);
`ifdef CACHE_STATS_EN
        check("stats_hit_lit", hit_cnt, 1);
        check("stats_miss_lit", miss_cnt, 1);
`endif

        // Write hit dirties set 16; conflicting read forces write-back before refill
        access(1'b1, 32'h40, 32'h1234, lat);
        check("wr_hit_latency_lit", lat, 1);
        access(1'b0, 32'h1040, 32'h0, lat);
        check("evict_mem_count", obs_mem.size(), 2);
        if (obs_mem.size() == 2) begin
            check("evict_wb_we", obs_mem[0].we, 1);
            check("evict_wb_addr", obs_mem[0].addr, 32'h40);
            check("evict_wb_data", obs_mem[0].wdata, 32'h1234);
            check("evict_rf_we", obs_mem[1].we, 0);
            check("evict_rf_addr", obs_mem[1].addr, 32'h1040);
        end

        // Write miss to an invalid set: no memory traffic
        access(1'b1, 32'h80, 32'hCAFE_F00D, lat);
        check("wmiss_no_mem", obs_mem.size(), 0);
        check("wmiss_tag_lit", tag_arr[0], 27'h600_0001);
        check("wmiss_latency_lit", lat, 1);

        reset_abort();

        // Random traffic over a few sets and tags to provoke conflicts
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 3)) * 128 + 32'($urandom_range(0, 7)) * 4
               + 32'($urandom_range(0, 3));
            access(we, a, $urandom, lat);
        end
`ifdef CACHE_STATS_EN
        check("stats_hit_final", hit_cnt, mdl_hits);
        check("stats_miss_final", miss_cnt, mdl_misses);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter OFFSET_W, default 2, byte-offset bits (one 32-bit word per line).
REQ-003 SHALL have parameter IDX_W, default 5, index bits; TAG_W = ADDR_W-IDX_W-OFFSET_W; TAG_MEM_W = TAG_W+2.
REQ-004 SHALL have port iCLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port iRST_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports cpu_req/cpu_we  in  1/1  CPU access request held until accepted / write select.
REQ-007 SHALL have ports cpu_addr/cpu_wdata  in  ADDR_W/32  access address / store data.
REQ-008 SHALL have ports cpu_rdata/cpu_ready  out  32/1  load data / one-cycle completion pulse.
REQ-009 SHALL have ports mem_req/mem_we  out  1/1  backing-memory request held until mem_ack / write select.
REQ-010 SHALL have ports mem_addr/mem_wdata  out  ADDR_W/32  word-aligned address / write-back data.
REQ-011 SHALL have ports mem_rdata/mem_ack  in  32/1  refill data / one-cycle completion, rdata valid with ack.
REQ-012 SHALL have ports idx/tag_we/tag_block_in  out  IDX_W/1/TAG_MEM_W  shared index, tag write, tag block {valid,dirty,tag}.
REQ-013 SHALL have ports tag_block_out/data_out  in  TAG_MEM_W/32  combinational tag-array and data-array read.
REQ-014 SHALL have ports data_we/data_in  out  1/32  data-array write enable and word.

Function
REQ-015 SHALL implement FSM states INIT, IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-016 SHALL in INIT sweep idx 0..2^IDX_W-1, one per cycle, tag_we=1, tag_block_in=0, then enter IDLE; cpu_ready=0 throughout.
REQ-017 SHALL in IDLE with cpu_req=1 latch cpu_addr, cpu_we, cpu_wdata and go to COMPARE next cycle.
REQ-018 SHALL drive idx from the latched address bits [OFFSET_W+IDX_W-1:OFFSET_W] in all states except INIT.
REQ-019 SHALL declare hit in COMPARE when valid=1 and stored tag equals latched tag.
REQ-020 SHALL on read hit pulse cpu_ready with cpu_rdata=data_out in COMPARE (accept-to-ready latency 1 cycle), return to IDLE.
REQ-021 SHALL on write hit write data_in=cpu_wdata, tag_block_in={1,1,tag}, pulse cpu_ready, return to IDLE.
REQ-022 SHALL on miss with valid&dirty go to WRITEBACK: mem_req=1, mem_we=1, mem_addr={stored tag,idx,0}, mem_wdata=data_out until mem_ack.
REQ-023 SHALL on read miss (clean, or after WRITEBACK ack) go to ALLOCATE: mem_req=1, mem_we=0, mem_addr={tag,idx,0}; on mem_ack write data_in=mem_rdata, tag {1,0,tag}, then return to COMPARE (guaranteed hit).
REQ-024 SHALL on write miss skip ALLOCATE (full-word line) and return to COMPARE after eviction, completing as write hit.
REQ-025 SHALL hold mem_req, mem_we, mem_addr, mem_wdata stable until mem_ack; deassert mem_req the cycle after ack.
REQ-026 SHALL ignore cpu_req outside IDLE; cpu_ready SHALL never pulse twice per request.

Reset
REQ-027 SHALL on iRST_N=0 at any time enter INIT, clear cpu_ready, mem_req, tag_we, data_we, counters, aborting any in-flight access.
REQ-028 SHALL tolerate a mem_ack arriving after reset abort by ignoring it in INIT.

Configuration
REQ-029 SHALL with CACHE_STATS_EN defined add outputs hit_cnt and miss_cnt (32 bits each), incremented once per COMPARE first-lookup outcome, saturating at all-ones.
REQ-030 SHALL without CACHE_STATS_EN omit those ports and counters entirely.

Structure
REQ-031 SHALL place state encoding and tag-block field positions (VALID_POS, DIRTY_POS) in shared package cache_pkg.
REQ-032 SHALL be a single FSM module; the tag and data arrays remain external instances sharing idx.

Verification
REQ-033 SHALL check reset release: INIT lasts 32 cycles with tag_we=1, idx 0..31, then IDLE; cpu_ready stays 0.
REQ-034 SHALL check read 0x0000_0040 cold: mem read of 0x40, mem_rdata=0xDEADBEEF -> cpu_rdata=0xDEADBEEF; repeat -> ready 1 cycle after accept, no mem_req.
REQ-035 SHALL check write 0x40=0x1234 hit, then read 0x1040 (same idx 16) -> write-back of 0x1234 to 0x40 precedes refill from 0x1040.
REQ-036 SHALL check write miss to clean line 0x80 -> no mem_req; tag {1,1,tag} written, ready pulses.
REQ-037 SHALL check iRST_N low during ALLOCATE with mem_ack delayed -> mem_req drops, late ack ignored, INIT restarts.
REQ-038 SHALL check with CACHE_STATS_EN: the two cold-miss, hit sequence of REQ-034 -> miss_cnt=1, hit_cnt=1.
